// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising per-core requests onto a shared single-port RAM.
// Each transaction takes IDLE -> ACCESS -> RESP, and every output is registered.
module mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    CORE_REQ,
  input  logic [NUM_CORES-1:0]    CORE_WE,
  input  logic [NUM_CORES*AW-1:0] CORE_ADDR,
  input  logic [NUM_CORES*DW-1:0] CORE_WDATA,
  output logic [NUM_CORES-1:0]    CORE_ACK,
  output logic [DW-1:0]           CORE_RDATA,
  output logic [AW-1:0]           MEM_ADDR,
  output logic [DW-1:0]           MEM_WDATA,
  output logic                    MEM_WR,
  output logic                    MEM_RD,
  input  logic [DW-1:0]           MEM_RDATA
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]                     state;
  logic [IW-1:0]                  last_grant;
  logic [IW-1:0]                  win;
  logic [IW-1:0]                  pick;
  logic                           found;
  int                             idx;
  logic [NUM_CORES-1:0][AW-1:0]   addr_a;
  logic [NUM_CORES-1:0][DW-1:0]   wdata_a;

  assign addr_a  = CORE_ADDR;
  assign wdata_a = CORE_WDATA;

  // Scan upward from the core after the last grant, wrapping; first requester wins.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = (int'(last_grant) + k) % NUM_CORES;
      if (!found && CORE_REQ[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  // The output registers double as the latched request, so MEM_RD tells
  // ACCESS whether this is a read that needs its data captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_CORES - 1);
      win        <= '0;
      CORE_ACK   <= '0;
      CORE_RDATA <= '0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      MEM_WR     <= 1'b0;
      MEM_RD     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CORE_ACK <= '0;
          MEM_WR   <= 1'b0;
          MEM_RD   <= 1'b0;
          if (|CORE_REQ) begin
            win       <= pick;
            MEM_ADDR  <= addr_a[pick];
            MEM_WR    <= CORE_WE[pick];
            MEM_RD    <= !CORE_WE[pick];
            MEM_WDATA <= CORE_WE[pick] ? wdata_a[pick] : '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          MEM_WR <= 1'b0;
          MEM_RD <= 1'b0;
          if (MEM_RD) CORE_RDATA <= MEM_RDATA;
          CORE_ACK[win] <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          CORE_ACK   <= '0;
          last_grant <= win;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
